// File: rtl/uart_pkg.sv
// Shared constants for the 64-bit UART transmit path: FSM encoding,
// default line parameters and 8N1 frame geometry.
package uart_pkg;

    // Byte-serializer state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Default clock and baud rate
    localparam int DEF_CLK_FREQ = 50_000_000;
    localparam int DEF_UART_BPS = 115_200;

    // Frame geometry: 8 data bits, 8 bytes per word, start + 8 data + stop
    localparam int DATA_BITS      = 8;
    localparam int BYTES_PER_WORD = 8;
    localparam int BITS_PER_FRAME = 10;

endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte 8N1 serializer. Owns the baud counter and START/DATA/STOP
// sequencing. The byte is read live from i_byte_data (the parent holds it
// stable for the whole byte). i_byte_start is honoured in IDLE and on the
// last clock of STOP, so consecutive bytes follow with no idle gap.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int BPS_CNT = DEF_CLK_FREQ / DEF_UART_BPS
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       i_byte_start,
    input  logic [7:0] i_byte_data,
    output logic       o_txd,
    output logic       o_byte_done
);

    localparam int               CNT_W    = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);
    localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_idx;
    logic             r_txd;

    logic             w_bit_end;
    logic [2:0]       w_bit_next;

    assign w_bit_end   = (r_baud_cnt == CNT_LAST);
    assign w_bit_next  = r_bit_idx + 3'd1;
    assign o_byte_done = (r_state == ST_STOP) && w_bit_end;
    assign o_txd       = r_txd;

    // Bit-period sequencing; the line register is loaded with the level of the
    // period that begins at this edge, so the line changes exactly on bit edges.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_state    <= ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_txd      <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_baud_cnt <= '0;
                    r_bit_idx  <= '0;
                    r_txd      <= 1'b1;
                    if (i_byte_start) begin
                        r_state <= ST_START;
                        r_txd   <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_state    <= ST_DATA;
                        r_txd      <= i_byte_data[0];
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == BIT_LAST) begin
                            r_bit_idx <= '0;
                            r_state   <= ST_STOP;
                            r_txd     <= 1'b1;
                        end else begin
                            r_bit_idx <= w_bit_next;
                            r_txd     <= i_byte_data[w_bit_next];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                default: begin // ST_STOP
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (i_byte_start) begin
                            r_state <= ST_START;
                            r_txd   <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_txd   <= 1'b1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_send64.sv
// Sends a 64-bit word as 8 UART bytes, MSB byte first, triggered by a rising
// edge of send_en. tx_busy covers the whole word; tx_done pulses once at the end.
module uart_send64
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = DEF_CLK_FREQ,
    parameter int UART_BPS = DEF_UART_BPS
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        send_en,
    input  logic [63:0] send_data,
    output logic        uart_txd,
    output logic        tx_busy,
    output logic        tx_done
);

    localparam int         BPS_CNT   = CLK_FREQ / UART_BPS;
    localparam logic [2:0] BYTE_LAST = 3'(BYTES_PER_WORD - 1);

    logic        r_send_en_d0;
    logic [63:0] r_tx_buf;
    logic [2:0]  r_byte_idx;
    logic        r_tx_busy;
    logic        r_tx_done;

    logic        w_start_flag;
    logic        w_accept;
    logic        w_byte_done;
    logic        w_last_byte;
    logic        w_byte_start;
    logic [2:0]  w_byte_sel;
    logic [7:0]  w_cur_byte;

    // Edges arriving while busy (including the cycle tx_busy falls) are dropped.
    assign w_start_flag = send_en & ~r_send_en_d0;
    assign w_accept     = w_start_flag & ~r_tx_busy;
    assign w_last_byte  = (r_byte_idx == BYTE_LAST);
    assign w_byte_start = w_accept | (w_byte_done & ~w_last_byte);

    // byte 0 is bits 63:56
    assign w_byte_sel   = BYTE_LAST - r_byte_idx;
    assign w_cur_byte   = r_tx_buf[{w_byte_sel, 3'b000} +: 8];

    assign tx_busy = r_tx_busy;
    assign tx_done = r_tx_done;

    // Delay send_en by one clock for rising-edge detection
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_send_en_d0 <= 1'b0;
        end else begin
            r_send_en_d0 <= send_en;
        end
    end

    // Word latch, byte sequencing and busy/done reporting
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_tx_buf   <= '0;
            r_byte_idx <= '0;
            r_tx_busy  <= 1'b0;
            r_tx_done  <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            if (w_accept) begin
                r_tx_buf   <= send_data;
                r_byte_idx <= '0;
                r_tx_busy  <= 1'b1;
            end else if (w_byte_done) begin
                if (w_last_byte) begin
                    r_byte_idx <= '0;
                    r_tx_busy  <= 1'b0;
                    r_tx_done  <= 1'b1;
                end else begin
                    r_byte_idx <= r_byte_idx + 3'd1;
                end
            end
        end
    end

    uart_byte_tx #(
        .BPS_CNT (BPS_CNT)
    ) u_byte_tx (
        .clk          (sys_clk),
        .srst         (sys_rst),
        .i_byte_start (w_byte_start),
        .i_byte_data  (w_cur_byte),
        .o_txd        (uart_txd),
        .o_byte_done  (w_byte_done)
    );

endmodule

// File: tb/tb_uart_send64.sv
// Bench for uart_send64 at 10 clocks per bit: a per-cycle reference model of
// the line/busy/done waveform, a mid-bit UART decoder, and directed scenarios.
module tb_uart_send64;

    localparam int BPS       = 10;
    localparam int WORD_CLKS = 800;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        send_en = 1'b0;
    logic [63:0] send_data = '0;
    logic        uart_txd;
    logic        tx_busy;
    logic        tx_done;

    int checks = 0;
    int errors = 0;

    uart_send64 #(
        .CLK_FREQ (1_000_000),
        .UART_BPS (100_000)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .send_en   (send_en),
        .send_data (send_data),
        .uart_txd  (uart_txd),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    always #5 sys_clk = ~sys_clk;

    // Line level at clock k (0-based) of a word: each byte is 10 bit periods
    // (start 0, data LSB first, stop 1), bytes taken MSB first.
    function automatic logic line_bit(input logic [63:0] w, input int k);
        int p, bi, pos;
        logic [7:0] b;
        p   = k / BPS;
        bi  = p / 10;
        pos = p % 10;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        b = w[63 - 8*bi -: 8];
        return b[pos - 1];
    endfunction

    // Reference model: one word in flight at most, accepted on an input rising
    // edge only when idle; done lands WORD_CLKS edges after acceptance.
    int          cyc = 0;
    int          m_e = 0;
    logic        m_active = 1'b0;
    logic        m_prev = 1'b0;
    logic [63:0] m_word = '0;
    logic        exp_txd = 1'b1;
    logic        exp_busy = 1'b0;
    logic        exp_done = 1'b0;

    always @(posedge sys_clk) begin : model
        int   n;
        logic sf;
        n  = cyc + 1;
        cyc <= n;
        if (sys_rst) begin
            m_active <= 1'b0;
            m_prev   <= 1'b0;
            exp_txd  <= 1'b1;
            exp_busy <= 1'b0;
            exp_done <= 1'b0;
        end else begin
            sf = send_en & ~m_prev;
            m_prev <= send_en;
            if (m_active && (n - m_e) == WORD_CLKS) begin
                m_active <= 1'b0;
                exp_txd  <= 1'b1;
                exp_busy <= 1'b0;
                exp_done <= 1'b1;
            end else if (m_active) begin
                exp_txd  <= line_bit(m_word, n - m_e);
                exp_busy <= 1'b1;
                exp_done <= 1'b0;
            end else if (sf) begin
                m_active <= 1'b1;
                m_e      <= n;
                m_word   <= send_data;
                exp_txd  <= 1'b0;
                exp_busy <= 1'b1;
                exp_done <= 1'b0;
            end else begin
                exp_txd  <= 1'b1;
                exp_busy <= 1'b0;
                exp_done <= 1'b0;
            end
        end
    end

    // Running totals of busy cycles, done pulses and line transitions
    int   busy_tot = 0;
    int   done_tot = 0;
    int   tog_tot  = 0;
    logic prev_txd = 1'b1;

    always @(negedge sys_clk) begin
        if (tx_busy === 1'b1) busy_tot <= busy_tot + 1;
        if (tx_done === 1'b1) done_tot <= done_tot + 1;
        if (uart_txd !== prev_txd) tog_tot <= tog_tot + 1;
        prev_txd <= uart_txd;
    end

    // Independent UART receiver sampling mid-bit
    logic [7:0] dec_q[$];

    always begin : decoder
        logic [7:0] b;
        @(negedge sys_clk);
        if (!sys_rst && uart_txd === 1'b0) begin
            b = '0;
            repeat (5) @(negedge sys_clk);
            for (int i = 0; i < 8; i++) begin
                repeat (10) @(negedge sys_clk);
                b[i] = uart_txd;
            end
            repeat (10) @(negedge sys_clk);
            dec_q.push_back(b);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_done(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge sys_clk);
            if (tx_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, "_done_seen"}, {63'd0, ok}, 64'd1);
    endtask

    task automatic chk_bytes(input string name, input int base, input logic [63:0] w);
        for (int b = 0; b < 8; b++) begin
            logic [7:0] got;
            got = (base + b < dec_q.size()) ? dec_q[base + b] : 8'hxx;
            chk($sformatf("%s_byte%0d", name, b), {56'd0, got}, {56'd0, w[63 - 8*b -: 8]});
        end
    endtask

    localparam logic [63:0] W_BASIC = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] W_HOLD  = 64'hA55A_3CC3_0FF0_8001;
    localparam logic [63:0] W_BUSY  = 64'h1357_9BDF_2468_ACE0;
    localparam logic [63:0] W_B2B   = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [63:0] W_EDGE  = 64'h7E81_42BD_18E7_66AA;
    localparam logic [63:0] W_RST   = 64'h0011_2233_4455_6677;
    localparam logic [63:0] W_REL   = 64'hC001_D00D_FACE_B00C;

    initial begin
        logic [7:0] exp1 [8];
        int base, b0, d0, t0;
        exp1 = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};

        // Every-cycle comparison against the reference model
        fork
            forever begin
                @(negedge sys_clk);
                if (cyc > 0) begin
                    chk("model_txd",  {63'd0, uart_txd}, {63'd0, exp_txd});
                    chk("model_busy", {63'd0, tx_busy},  {63'd0, exp_busy});
                    chk("model_done", {63'd0, tx_done},  {63'd0, exp_done});
                end
            end
        join_none

        // Reset state
        repeat (3) @(negedge sys_clk);
        chk("rst_txd",  {63'd0, uart_txd}, 64'd1);
        chk("rst_busy", {63'd0, tx_busy},  64'd0);
        chk("rst_done", {63'd0, tx_done},  64'd0);
        sys_rst = 1'b0;
        repeat (3) @(negedge sys_clk);

        // Basic word, literal byte expectations
        base = dec_q.size(); b0 = busy_tot; d0 = done_tot;
        send_data = W_BASIC; send_en = 1'b1;
        @(negedge sys_clk);
        chk("basic_start_txd",  {63'd0, uart_txd}, 64'd0);
        chk("basic_start_busy", {63'd0, tx_busy},  64'd1);
        send_en = 1'b0;
        wait_done("basic");
        repeat (3) @(negedge sys_clk);
        chk("basic_nbytes", 64'(dec_q.size() - base), 64'd8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("basic_lit%0d", i), {56'd0, dec_q[base + i]}, {56'd0, exp1[i]});
        chk("basic_busy_clks", 64'(busy_tot - b0), 64'd800);
        chk("basic_done_pulses", 64'(done_tot - d0), 64'd1);
        $display("word basic: sent %h", W_BASIC);

        // Level hold: send_en high for 2000 clocks sends exactly one word
        base = dec_q.size(); b0 = busy_tot; d0 = done_tot;
        send_data = W_HOLD; send_en = 1'b1;
        repeat (2000) @(negedge sys_clk);
        chk("hold_idle_txd", {63'd0, uart_txd}, 64'd1);
        chk("hold_nbytes", 64'(dec_q.size() - base), 64'd8);
        chk_bytes("hold", base, W_HOLD);
        chk("hold_busy_clks", 64'(busy_tot - b0), 64'd800);
        chk("hold_done_pulses", 64'(done_tot - d0), 64'd1);
        send_en = 1'b0;
        repeat (3) @(negedge sys_clk);
        $display("word hold: sent %h", W_HOLD);

        // Busy rejection: new edge with new data at clock 300 of a frame
        base = dec_q.size(); b0 = busy_tot; d0 = done_tot;
        send_data = W_BUSY; send_en = 1'b1;
        repeat (290) @(negedge sys_clk);
        send_en = 1'b0;
        repeat (10) @(negedge sys_clk);
        send_data = 64'hFFFF_FFFF_FFFF_FFFF; send_en = 1'b1;
        wait_done("busy");
        repeat (1000) @(negedge sys_clk);
        chk("busy_nbytes", 64'(dec_q.size() - base), 64'd8);
        chk_bytes("busy", base, W_BUSY);
        chk("busy_busy_clks", 64'(busy_tot - b0), 64'd800);
        chk("busy_done_pulses", 64'(done_tot - d0), 64'd1);
        send_en = 1'b0;
        repeat (3) @(negedge sys_clk);
        $display("word busy-reject: sent %h", W_BUSY);

        // Back-to-back: fresh edge in the tx_done cycle is accepted
        base = dec_q.size(); b0 = busy_tot; d0 = done_tot;
        send_data = W_B2B; send_en = 1'b1;
        @(negedge sys_clk);
        send_en = 1'b0;
        wait_done("b2b_first");
        send_data = 64'h0; send_en = 1'b1;
        @(negedge sys_clk);
        chk("b2b_start_txd",  {63'd0, uart_txd}, 64'd0);
        chk("b2b_start_busy", {63'd0, tx_busy},  64'd1);
        send_en = 1'b0;
        wait_done("b2b_second");
        repeat (3) @(negedge sys_clk);
        chk("b2b_nbytes", 64'(dec_q.size() - base), 64'd16);
        chk_bytes("b2b_w1", base, W_B2B);
        chk_bytes("b2b_w2", base + 8, 64'h0);
        chk("b2b_busy_clks", 64'(busy_tot - b0), 64'd1600);
        chk("b2b_done_pulses", 64'(done_tot - d0), 64'd2);
        $display("word back-to-back: sent %h then %h", W_B2B, 64'h0);

        // Edge landing on the clock where tx_busy falls is ignored
        base = dec_q.size(); d0 = done_tot;
        send_data = W_EDGE; send_en = 1'b1;
        @(negedge sys_clk);
        send_en = 1'b0;
        repeat (799) @(negedge sys_clk);
        chk("edge_still_busy", {63'd0, tx_busy}, 64'd1);
        send_data = 64'hFFFF_FFFF_FFFF_FFFF; send_en = 1'b1;
        @(negedge sys_clk);
        chk("edge_done", {63'd0, tx_done}, 64'd1);
        chk("edge_busy_low", {63'd0, tx_busy}, 64'd0);
        repeat (1000) @(negedge sys_clk);
        chk("edge_nbytes", 64'(dec_q.size() - base), 64'd8);
        chk_bytes("edge", base, W_EDGE);
        chk("edge_done_pulses", 64'(done_tot - d0), 64'd1);
        send_en = 1'b0;
        repeat (3) @(negedge sys_clk);
        $display("word edge-at-done: sent %h", W_EDGE);

        // Mid-frame reset at clock 415
        send_data = W_RST; send_en = 1'b1;
        @(negedge sys_clk);
        send_en = 1'b0;
        repeat (414) @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        chk("mrst_txd",  {63'd0, uart_txd}, 64'd1);
        chk("mrst_busy", {63'd0, tx_busy},  64'd0);
        chk("mrst_done", {63'd0, tx_done},  64'd0);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        b0 = busy_tot; d0 = done_tot; t0 = tog_tot;
        repeat (900) @(negedge sys_clk);
        chk("mrst_toggles", 64'(tog_tot - t0), 64'd0);
        chk("mrst_busy_clks", 64'(busy_tot - b0), 64'd0);
        chk("mrst_done_pulses", 64'(done_tot - d0), 64'd0);
        $display("word mid-reset: %h abandoned", W_RST);

        // Reset release with send_en already high starts a frame at once
        base = dec_q.size();
        sys_rst = 1'b1; send_en = 1'b1; send_data = W_REL;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("rel_start_txd",  {63'd0, uart_txd}, 64'd0);
        chk("rel_start_busy", {63'd0, tx_busy},  64'd1);
        wait_done("rel");
        repeat (3) @(negedge sys_clk);
        chk("rel_nbytes", 64'(dec_q.size() - base), 64'd8);
        chk_bytes("rel", base, W_REL);
        send_en = 1'b0;
        repeat (3) @(negedge sys_clk);
        $display("word reset-release: sent %h", W_REL);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_send64.md
# uart_send64

Transmit stage downstream of the encryption loop. Accepts a 64-bit ciphertext word on the rising edge of `send_en` and serializes it onto a UART line as 8 bytes, most-significant byte first, using 8N1 framing. It reports `tx_busy` back to the encryption loop so that no new word is issued mid-frame. A `tx_done` pulse marks completion of the whole word.

## Interface
- `CLK_FREQ`, default 50_000_000: `sys_clk` frequency in Hz.
- `UART_BPS`, default 115200: line baud rate.
- `BPS_CNT`, derived as CLK_FREQ/UART_BPS (integer division, must be ≥ 2): clocks per bit.
- `sys_clk`, in, 1: the single clock.
- `sys_rst`, in, 1: reset, synchronous, active-high.
- `send_en`, in, 1: level from upstream; only a 0→1 transition requests a transmission.
- `send_data`, in, 64: word to send; valid in the cycle the rising edge is detected.
- `uart_txd`, out, 1: serial line, idle high.
- `tx_busy`, out, 1: high while a word is in flight.
- `tx_done`, out, 1: one-cycle pulse after the last stop bit.

## Operation
- Edge detection:
  - `send_en_d0` registers `send_en`.
  - `start_flag = send_en & ~send_en_d0`.
  - Upstream holds `send_en` high for an arbitrary time, so level-triggering is forbidden.
- FSM states:
  - IDLE:
    - `uart_txd`=1, `tx_busy`=0.
    - On `start_flag`: latch `send_data` into `tx_buf`, byte_idx=0, go to START.
  - START: drive 0 for BPS_CNT clocks, then go to DATA with bit_idx=0.
  - DATA:
    - Drive `cur_byte[bit_idx]`, LSB first, for BPS_CNT clocks per bit.
    - After bit 7, go to STOP.
  - STOP:
    - Drive 1 for BPS_CNT clocks.
    - Then, if byte_idx<7: byte_idx+1, go to START, with no idle gap.
    - Else: go to IDLE and pulse `tx_done`.
- Byte selection: `cur_byte = tx_buf[63-8*byte_idx -: 8]` (byte 0 = bits 63:56).
- Counters:
  - baud_cnt runs 0..BPS_CNT-1 and clears on every state or bit change.
  - bit_idx runs 0..7.
  - byte_idx runs 0..7.
  - None of these wrap outside their active state; all are held at 0 in IDLE.
- `start_flag` outside IDLE is ignored and never queued; `tx_buf` is not modified.
- `send_data` changing while busy has no effect.
- Reset at any point:
  - Next edge: state IDLE, `uart_txd`=1, `tx_busy`=0, `tx_done`=0, `send_en_d0`=0, all counters 0.
  - A partially sent frame is abandoned.
  - If `send_en` is high when reset releases, a rising edge is detected on the first post-reset cycle. This is intentional, because `send_en_d0` resets to 0.

## Timing
- Reset values: `uart_txd`=1, `tx_busy`=0, `tx_done`=0.
- Let E be the clock edge at which `start_flag` is high in IDLE.
  - From E: `uart_txd`=0 and `tx_busy`=1, registered, so visible after E.
  - Latency from the `send_en` rise to the start bit is 1 clock.
- Each bit lasts exactly BPS_CNT clocks.
- One word is 8 × 10 = 80 bit periods.
- `tx_busy` stays high for exactly 80·BPS_CNT clocks.
  - At edge E+80·BPS_CNT: `tx_busy`→0, `tx_done`=1 for one clock, `uart_txd` stays 1.
- `start_flag` in the same cycle that `tx_busy` falls is ignored, because the state is still STOP.
  - Upstream must produce a fresh rising edge afterwards.
- `start_flag` on the first IDLE cycle after `tx_done` is accepted.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding (IDLE/START/DATA/STOP, 2 bits).
  - Default CLK_FREQ/UART_BPS constants.
  - Frame constants: DATA_BITS=8, BYTES_PER_WORD=8, BITS_PER_FRAME=10.
- One natural sub-module: `uart_byte_tx`.
  - Owns the baud counter and the START/DATA/STOP sequencing for a single byte.
  - Its handshake is byte_start/byte_done.
- `uart_send64` keeps the edge detect, `tx_buf`, byte_idx, `tx_busy` and `tx_done`.

## Test plan
Bench parameters: CLK_FREQ=1_000_000, UART_BPS=100_000, so BPS_CNT=10.
- Basic word: `send_en` 0→1 with `send_data`=64'h0123_4567_89AB_CDEF.
  - Line decodes bytes 01,23,45,67,89,AB,CD,EF in that order.
  - Each bit is 10 clocks wide.
  - `tx_busy` is high for exactly 800 clocks.
  - `tx_done` is a single pulse at clock 800.
- Level hold: keep `send_en` high for 2000 clocks.
  - Exactly one word is sent.
  - `uart_txd` stays 1 after `tx_done`.
- Busy rejection: toggle `send_en` 0→1 at clock 300 of a frame, with a new `send_data`=64'hFFFF_FFFF_FFFF_FFFF.
  - The original word completes unchanged.
  - No second frame follows.
- Back-to-back: a new rising edge on the first cycle after `tx_done`, with data 64'h0000_0000_0000_0000.
  - Start bit appears 1 clock later.
  - Line decodes eight 00 bytes.
- Mid-frame reset: assert `sys_rst` for 1 clock at clock 415.
  - Next cycle: `uart_txd`=1, `tx_busy`=0, `tx_done`=0.
  - No further toggling until a new `send_en` edge.
- Reset release with `send_en` high: the first post-reset clock starts a frame with the current `send_data`.
